ame_equation_builder: RTL and testbench



---
 rtl/ame_pkg.sv | 10 +
 rtl/ame_coeff_gen.sv | 71 +++++++
 rtl/ame_equation_builder.sv | 118 +++++++++++
 tb/tb_ame_equation_builder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ame_pkg.sv
// Shared types and index constants for the affine motion-estimation equation path.
package ame_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} ame_eb_state_t;

  localparam int AME_B_COL     = 6;
  localparam int AME_P4_LO     = 2;
  localparam int AME_DATA_BITS = 64;

  typedef logic [5:0][6:0][AME_DATA_BITS-1:0] ame_matrix_t;
endpackage

// File: rtl/ame_coeff_gen.sv
// Stage 1: builds and registers the 6-entry coefficient vector and the scaled residual.
// One cycle latency, accepts a sample every cycle; flush drops the stage valid bit.
module ame_coeff_gen
  import ame_pkg::*;
#(
  parameter int GRAD_BITS  = 16,
  parameter int COORD_BITS = 8,
  parameter int RES_SHIFT  = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               mode6_i,
  input  logic                               valid_i,
  input  logic [GRAD_BITS-1:0]               grad_x_i,
  input  logic [GRAD_BITS-1:0]               grad_y_i,
  input  logic [COORD_BITS-1:0]              pos_x_i,
  input  logic [COORD_BITS-1:0]              pos_y_i,
  input  logic [GRAD_BITS-1:0]               diff_i,
  output logic                               valid_o,
  output logic [5:0][GRAD_BITS+COORD_BITS:0] coef_o,
  output logic [GRAD_BITS+RES_SHIFT-1:0]     res_o
);
  localparam int CB = GRAD_BITS + COORD_BITS + 1;

  logic [CB-1:0] gx, gy, px, py;
  logic [CB-1:0] gx_px, gy_px, gx_py, gy_py;
  logic [5:0][CB-1:0] coef_d, coef_q;
  logic [GRAD_BITS+RES_SHIFT-1:0] res_q;
  logic vld_q;

  assign gx = {{(CB-GRAD_BITS){grad_x_i[GRAD_BITS-1]}}, grad_x_i};
  assign gy = {{(CB-GRAD_BITS){grad_y_i[GRAD_BITS-1]}}, grad_y_i};
  assign px = {{(CB-COORD_BITS){pos_x_i[COORD_BITS-1]}}, pos_x_i};
  assign py = {{(CB-COORD_BITS){pos_y_i[COORD_BITS-1]}}, pos_y_i};

  // Operands are sign-extended to CB, so the truncated products are exact.
  assign gx_px = gx * px;
  assign gy_px = gy * px;
  assign gx_py = gx * py;
  assign gy_py = gy * py;

  always_comb begin
    coef_d    = '0;
    coef_d[5] = gx;
    coef_d[3] = gy;
    coef_d[1] = gx_py;
    coef_d[0] = gy_py;
    if (mode6_i) begin
      coef_d[4] = gx_px;
      coef_d[2] = gy_px;
    end else begin
      coef_d[4] = gx_px + gy_py;
      coef_d[2] = gy_px - gx_py;
      for (int i = 0; i < AME_P4_LO; i++) coef_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) vld_q <= 1'b0;
    else                  vld_q <= valid_i;
    if (valid_i) begin
      coef_q <= coef_d;
      res_q  <= {diff_i, {RES_SHIFT{1'b0}}};
    end
  end

  assign valid_o = vld_q;
  assign coef_o  = coef_q;
  assign res_o   = res_q;
endmodule

// File: rtl/ame_equation_builder.sv
// Accumulates the symmetric normal-equation matrix A and vector B; last sample to comp_done_o is 3 cycles.
// One sample per cycle; sample_ready_o drops outside ACCUM and whenever comp_init_i is high.
module ame_equation_builder
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int GRAD_BITS      = 16,
  parameter int COORD_BITS     = 8,
  parameter int RES_SHIFT      = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                comp_init_i,
  input  logic                                affine_param6_i,
  input  logic                                sample_valid_i,
  output logic                                sample_ready_o,
  input  logic                                sample_last_i,
  input  logic [GRAD_BITS-1:0]                grad_x_i,
  input  logic [GRAD_BITS-1:0]                grad_y_i,
  input  logic [COORD_BITS-1:0]               pos_x_i,
  input  logic [COORD_BITS-1:0]               pos_y_i,
  input  logic [GRAD_BITS-1:0]                diff_i,
  output logic                                comp_done_o,
  output logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_o
);
  localparam int CB = GRAD_BITS + COORD_BITS + 1;
  localparam int DB = GRAD_BITS + RES_SHIFT;

  ame_eb_state_t state_q;
  logic mode6_q, drain_cnt_q, vld_s2_q, accept, vld_s1;
  logic [5:0][CB-1:0] coef_s1;
  logic [DB-1:0] res_s1;

  function automatic logic [COMP_DATA_BITS-1:0] sx_c(input logic [CB-1:0] v);
    return {{(COMP_DATA_BITS-CB){v[CB-1]}}, v};
  endfunction

  function automatic logic [COMP_DATA_BITS-1:0] sx_r(input logic [DB-1:0] v);
    return {{(COMP_DATA_BITS-DB){v[DB-1]}}, v};
  endfunction

  assign sample_ready_o = (state_q == ACCUM) && !comp_init_i;
  assign accept         = sample_valid_i && sample_ready_o;
  assign comp_done_o    = (state_q == DONE);

  ame_coeff_gen #(
    .GRAD_BITS (GRAD_BITS),
    .COORD_BITS(COORD_BITS),
    .RES_SHIFT (RES_SHIFT)
  ) u_coeff_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (comp_init_i),
    .mode6_i (mode6_q),
    .valid_i (accept),
    .grad_x_i(grad_x_i),
    .grad_y_i(grad_y_i),
    .pos_x_i (pos_x_i),
    .pos_y_i (pos_y_i),
    .diff_i  (diff_i),
    .valid_o (vld_s1),
    .coef_o  (coef_s1),
    .res_o   (res_s1)
  );

  // DRAIN lasts two cycles so DONE lines up with the last accumulator update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode6_q     <= 1'b0;
      drain_cnt_q <= 1'b0;
    end else if (comp_init_i) begin
      state_q     <= ACCUM;
      mode6_q     <= affine_param6_i;
      drain_cnt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ACCUM: if (accept && sample_last_i) begin
          state_q     <= DRAIN;
          drain_cnt_q <= 1'b0;
        end
        DRAIN: if (drain_cnt_q) state_q <= DONE;
               else             drain_cnt_q <= 1'b1;
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || comp_init_i) vld_s2_q <= 1'b0;
    else                      vld_s2_q <= vld_s1;
  end

  for (genvar r = 0; r < 6; r++) begin : g_row
    for (genvar c = 0; c <= r; c++) begin : g_a
      logic [COMP_DATA_BITS-1:0] prod_q, acc_q;
      always_ff @(posedge clk_i) begin
        if (vld_s1) prod_q <= sx_c(coef_s1[r]) * sx_c(coef_s1[c]);
        if (rst_i || comp_init_i) acc_q <= '0;
        else if (vld_s2_q)        acc_q <= acc_q + prod_q;
      end
      assign comp_data_o[r][c] = acc_q;
      if (c != r) begin : g_mirror
        assign comp_data_o[c][r] = acc_q;
      end
    end

    logic [COMP_DATA_BITS-1:0] prod_b_q, acc_b_q;
    always_ff @(posedge clk_i) begin
      if (vld_s1) prod_b_q <= sx_c(coef_s1[r]) * sx_r(res_s1);
      if (rst_i || comp_init_i) acc_b_q <= '0;
      else if (vld_s2_q)        acc_b_q <= acc_b_q + prod_b_q;
    end
    assign comp_data_o[r][AME_B_COL] = acc_b_q;
  end
endmodule

// File: tb/tb_ame_equation_builder.sv
// Bench for ame_equation_builder: fixed vectors, random streams vs a reference model, corner sequences.
module tb_ame_equation_builder;
  import ame_pkg::*;

  logic clk = 1'b0;
  logic rst, comp_init, affine6, svalid, slast;
  logic [15:0] gx_s, gy_s, diff_s;
  logic [7:0] px_s, py_s;
  logic ready, done, ready_w, done_w;
  ame_matrix_t data;
  logic [5:0][6:0][47:0] data_w;

  int chk_cnt = 0;
  int pass_cnt = 0;
  longint ma[6][6];
  longint mb[6];
  longint ea[6][6];
  longint eb[6];
  bit mm6;

  typedef struct {
    bit m6;
    int gx, gy, x, y, d;
    logic [20:0][63:0] a;
    logic [5:0][63:0]  b;
  } vec_t;
  vec_t tbl[4];

  ame_equation_builder dut (
    .clk_i(clk), .rst_i(rst), .comp_init_i(comp_init), .affine_param6_i(affine6),
    .sample_valid_i(svalid), .sample_ready_o(ready), .sample_last_i(slast),
    .grad_x_i(gx_s), .grad_y_i(gy_s), .pos_x_i(px_s), .pos_y_i(py_s), .diff_i(diff_s),
    .comp_done_o(done), .comp_data_o(data)
  );

  // Narrow-accumulator instance so that wrap-around is reachable in a short run.
  ame_equation_builder #(.COMP_DATA_BITS(48)) dut_w (
    .clk_i(clk), .rst_i(rst), .comp_init_i(comp_init), .affine_param6_i(affine6),
    .sample_valid_i(svalid), .sample_ready_o(ready_w), .sample_last_i(slast),
    .grad_x_i(gx_s), .grad_y_i(gy_s), .pos_x_i(px_s), .pos_y_i(py_s), .diff_i(diff_s),
    .comp_done_o(done_w), .comp_data_o(data_w)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
  endtask

  function automatic int tidx(int r, int c);
    return (r >= c) ? r * (r + 1) / 2 + c : c * (c + 1) / 2 + r;
  endfunction

  task automatic set_a(int i, int r, int c, longint v);
    tbl[i].a[tidx(r, c)] = v;
  endtask

  task automatic model_clear;
    for (int r = 0; r < 6; r++) begin
      mb[r] = 0;
      for (int c = 0; c < 6; c++) ma[r][c] = 0;
    end
  endtask

  task automatic model_add(int gx, int gy, int x, int y, int d);
    longint cv[6];
    longint lgx, lgy, lx, ly, ld;
    lgx = gx; lgy = gy; lx = x; ly = y; ld = d;
    for (int k = 0; k < 6; k++) cv[k] = 0;
    cv[5] = lgx;
    cv[3] = lgy;
    if (mm6) begin
      cv[4] = lgx * lx; cv[2] = lgy * lx; cv[1] = lgx * ly; cv[0] = lgy * ly;
    end else begin
      cv[4] = lgx * lx + lgy * ly;
      cv[2] = lgy * lx - lgx * ly;
    end
    for (int r = 0; r < 6; r++) begin
      mb[r] += cv[r] * (ld * 8);
      for (int c = 0; c < 6; c++) ma[r][c] += cv[r] * cv[c];
    end
  endtask

  task automatic load_model;
    for (int r = 0; r < 6; r++) begin
      eb[r] = mb[r];
      for (int c = 0; c < 6; c++) ea[r][c] = ma[r][c];
    end
  endtask

  task automatic load_tbl(int i);
    for (int r = 0; r < 6; r++) begin
      eb[r] = longint'(tbl[i].b[r]);
      for (int c = 0; c < 6; c++) ea[r][c] = longint'(tbl[i].a[tidx(r, c)]);
    end
  endtask

  task automatic compare_matrix(input string name, input bit wide);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        logic [63:0] e;
        e = (c < 6) ? ea[r][c] : eb[r];
        chk($sformatf("%s_%0d%0d", name, r, c), data[r][c], e);
        if (wide)
          chk($sformatf("%s_w48_%0d%0d", name, r, c), {16'h0, data_w[r][c]}, e & 64'h0000_ffff_ffff_ffff);
      end
    end
  endtask

  task automatic drive_sample(int gx, int gy, int x, int y, int d, bit last);
    gx_s = 16'(gx); gy_s = 16'(gy); px_s = 8'(x); py_s = 8'(y); diff_s = 16'(d);
    svalid = 1'b1;
    slast  = last;
  endtask

  task automatic start_block(input bit m6, input string name);
    comp_init = 1'b1;
    affine6   = m6;
    #1;
    chk({name, "_rdy_during_init"}, 64'(ready), 64'd0);
    tick;
    comp_init = 1'b0;
    #1;
    chk({name, "_rdy_after_init"}, 64'(ready), 64'd1);
    chk({name, "_zero_after_init"}, 64'(data == '0), 64'd1);
    model_clear;
    mm6 = m6;
  endtask

  task automatic send(int gx, int gy, int x, int y, int d, bit last);
    drive_sample(gx, gy, x, y, d, last);
    tick;
    model_add(gx, gy, x, y, d);
  endtask

  // Entered one cycle after the last sample was accepted.
  task automatic wait_done(input string name, input bit wide);
    svalid = 1'b0;
    slast  = 1'b0;
    chk({name, "_done_t1"}, 64'(done), 64'd0);
    tick;
    chk({name, "_done_t2"}, 64'(done), 64'd0);
    tick;
    chk({name, "_done_t3"}, 64'(done), 64'd1);
    compare_matrix(name, wide);
    tick;
    chk({name, "_done_t4"}, 64'(done), 64'd0);
    compare_matrix({name, "_hold"}, wide);
  endtask

  task automatic run_random(input bit m6, input int n, input bit bubbles, input string name);
    int sent;
    int gx, gy, x, y, d;
    start_block(m6, name);
    sent = 0;
    while (sent < n) begin
      gx = int'($urandom_range(65535)) - 32768;
      gy = int'($urandom_range(65535)) - 32768;
      x  = int'($urandom_range(255)) - 128;
      y  = int'($urandom_range(255)) - 128;
      d  = int'($urandom_range(65535)) - 32768;
      if (bubbles && $urandom_range(3) == 0) begin
        drive_sample(gx, gy, x, y, d, sent == n - 1);
        svalid = 1'b0;
        tick;
      end else begin
        send(gx, gy, x, y, d, sent == n - 1);
        sent++;
      end
    end
    load_model;
    wait_done(name, 1'b1);
  endtask

  initial begin
    rst = 1'b1; comp_init = 1'b0; affine6 = 1'b0; svalid = 1'b0; slast = 1'b0;
    gx_s = '0; gy_s = '0; px_s = '0; py_s = '0; diff_s = '0;

    for (int i = 0; i < 4; i++) begin
      tbl[i].a = '0;
      tbl[i].b = '0;
    end
    tbl[0].m6 = 1'b1; tbl[0].gx = 1; tbl[0].gy = 0; tbl[0].x = 2; tbl[0].y = 3; tbl[0].d = 5;
    set_a(0,5,5,1); set_a(0,5,4,2); set_a(0,4,4,4); set_a(0,5,1,3); set_a(0,4,1,6); set_a(0,1,1,9);
    tbl[0].b[5] = 40; tbl[0].b[4] = 80; tbl[0].b[1] = 120;
    tbl[1].m6 = 1'b0; tbl[1].gx = 2; tbl[1].gy = 1; tbl[1].x = 1; tbl[1].y = 1; tbl[1].d = -1;
    set_a(1,5,5,4); set_a(1,4,4,9); set_a(1,3,3,1); set_a(1,2,2,1); set_a(1,5,4,6);
    set_a(1,5,3,2); set_a(1,5,2,-2); set_a(1,4,3,3); set_a(1,4,2,-3); set_a(1,3,2,-1);
    tbl[1].b[5] = -16; tbl[1].b[4] = -24; tbl[1].b[3] = -8; tbl[1].b[2] = 8;
    tbl[2].m6 = 1'b0; tbl[2].gx = 0; tbl[2].gy = 3; tbl[2].x = 2; tbl[2].y = -1; tbl[2].d = 1;
    set_a(2,4,4,9); set_a(2,4,3,-9); set_a(2,4,2,-18); set_a(2,3,3,9); set_a(2,3,2,18); set_a(2,2,2,36);
    tbl[2].b[4] = -24; tbl[2].b[3] = 24; tbl[2].b[2] = 48;
    // c = {c5..c0} = {-2, 2, 1, -1, -4, 2}
    tbl[3].m6 = 1'b1; tbl[3].gx = -2; tbl[3].gy = 1; tbl[3].x = -1; tbl[3].y = 2; tbl[3].d = -3;
    set_a(3,0,0,4); set_a(3,1,0,-8); set_a(3,1,1,16); set_a(3,2,0,-2); set_a(3,2,1,4); set_a(3,2,2,1);
    set_a(3,3,0,2); set_a(3,3,1,-4); set_a(3,3,2,-1); set_a(3,3,3,1); set_a(3,4,0,4); set_a(3,4,1,-8);
    set_a(3,4,2,-2); set_a(3,4,3,2); set_a(3,4,4,4); set_a(3,5,0,-4); set_a(3,5,1,8); set_a(3,5,2,2);
    set_a(3,5,3,-2); set_a(3,5,4,-4); set_a(3,5,5,4);
    tbl[3].b[0] = -48; tbl[3].b[1] = 96; tbl[3].b[2] = 24; tbl[3].b[3] = -24; tbl[3].b[4] = -48; tbl[3].b[5] = 48;

    tick; tick;
    rst = 1'b0;
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_data", 64'(data == '0), 64'd1);

    // Samples offered in IDLE are ignored.
    drive_sample(5, 5, 5, 5, 5, 1'b1);
    #1;
    chk("idle_ready", 64'(ready), 64'd0);
    tick; tick; tick; tick;
    chk("idle_no_done", 64'(done), 64'd0);
    chk("idle_data", 64'(data == '0), 64'd1);
    svalid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      start_block(tbl[i].m6, $sformatf("vec%0d", i));
      send(tbl[i].gx, tbl[i].gy, tbl[i].x, tbl[i].y, tbl[i].d, 1'b1);
      load_tbl(i);
      wait_done($sformatf("vec%0d", i), 1'b0);
    end

    run_random(1'b1, 64, 1'b0, "rnd6");
    run_random(1'b0, 64, 1'b0, "rnd4");
    run_random(1'b1, 40, 1'b1, "bub6");
    run_random(1'b0, 40, 1'b1, "bub4");

    // Re-init while the previous block is draining.
    start_block(1'b1, "old");
    send(500, -700, 30, -40, 1234, 1'b1);
    drive_sample(7, 7, 7, 7, 7, 1'b1);
    start_block(1'b1, "reinit");
    svalid = 1'b0;
    tick;
    chk("reinit_no_old_done", 64'(done), 64'd0);
    chk("reinit_no_inflight", 64'(data == '0), 64'd1);
    send(tbl[0].gx, tbl[0].gy, tbl[0].x, tbl[0].y, tbl[0].d, 1'b1);
    load_tbl(0);
    wait_done("reinit", 1'b0);

    // Reset in the middle of a block with samples in flight.
    start_block(1'b0, "rst");
    send(1000, -2000, 10, 20, 300, 1'b0);
    send(-1500, 2500, -30, 40, -400, 1'b0);
    send(123, 456, 7, -8, 9, 1'b0);
    drive_sample(11, 12, 13, 14, 15, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", 64'(data == '0), 64'd1);
    chk("rst_data_w", 64'(data_w == '0), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk($sformatf("rst_no_done_%0d", k), 64'(done), 64'd0);
      chk($sformatf("rst_still_zero_%0d", k), 64'(data == '0), 64'd1);
    end
    svalid = 1'b0;
    slast  = 1'b0;

    // Extreme operands; the 48-bit instance must wrap, the 64-bit one must not.
    start_block(1'b1, "wrap6");
    for (int k = 0; k < 40; k++) send(-32768, -32768, -128, -128, -32768, k == 39);
    load_model;
    wait_done("wrap6", 1'b1);
    start_block(1'b0, "wrap4");
    for (int k = 0; k < 24; k++) send(-32768, 32767, -128, 127, 32767, k == 23);
    load_model;
    wait_done("wrap4", 1'b1);

    // Result must hold through IDLE traffic until the next init.
    for (int k = 0; k < 6; k++) begin
      drive_sample(int'($urandom_range(65535)) - 32768, 100, 3, 4, 5, 1'($urandom_range(1)));
      affine6 = 1'($urandom_range(1));
      tick;
      compare_matrix($sformatf("hold%0d", k), 1'b1);
    end
    svalid = 1'b0;
    comp_init = 1'b1;
    tick;
    comp_init = 1'b0;
    #1;
    chk("hold_cleared", 64'(data == '0), 64'd1);
    chk("hold_cleared_w", 64'(data_w == '0), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
